multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Sequential successor to the single-cycle CU. FSM controller for the multicycle MIPS datapath:
//  sequences FETCH/DECODE/EXEC/MEM/WB per instruction, handshakes with a variable-latency memory,
//  stalls on iterative MULT/DIV, retires one instruction at a time. Sits between IR/ALU flags and datapath muxes.
// PARAMETERS
//  ALUOP_W        5    width of alu_op; encodings from shared package
//  MULDIV_CYCLES  8    EXEC cycles for MULT/DIV (>=1)
//  MEM_TIMEOUT    64   max cycles waiting for mem_ready before fault-halt (0 = no timeout)
// PORTS
//  clk          in   1        clock; all state changes on rising edge
//  rst          in   1        synchronous, active-high reset
//  opcode       in   6        IR[31:26]; sampled only in DECODE
//  func         in   6        IR[5:0]; sampled only in DECODE
//  alu_zero     in   1        ALU zero flag, valid in EXEC
//  mem_ready    in   1        memory completes current request this cycle
//  mem_req      out  1        memory request, held until mem_ready
//  mem_we       out  1        write qualifier for mem_req (SW only)
//  ir_write     out  1        strobe: load IR
//  pc_write     out  1        strobe: update PC (source per jump/jump_reg/branch)
//  alu_op       out  ALUOP_W  ALU operation of current instruction
//  alu_src, reg_dest, mem_to_reg, link, sign_extend, jump, jump_reg, branch  out 1 each  datapath selects
//  reg_write    out  1        strobe: write register file
//  instr_done   out  1        1-cycle pulse on final cycle of each instruction
//  halted       out  1        sticky; unknown func or memory timeout
//  fault        out  1        sticky; halt caused by memory timeout
// BEHAVIOUR
//  Reset: state=FETCH; all outputs 0 except sign_extend=1; counters cleared. Reset mid-op abandons the instr;
//   mem_req drops at that edge with no write.
//  Selects (alu_op..branch) come from a control bundle registered in DECODE; held constant until next DECODE.
//  Strobes (ir_write, pc_write, reg_write, instr_done) are high only in the cycles listed below.
//  FETCH: mem_req=1, mem_we=0. On mem_ready: ir_write=1, pc_write=1 (PC+4) -> DECODE; else stay.
//  DECODE: latch bundle. Unknown R-func -> HALT. Unknown opcode -> NOP: instr_done -> FETCH.
//   J: pc_write, jump, instr_done -> FETCH. JAL: -> WB (link r31, jump). JR: pc_write, jump_reg, instr_done -> FETCH.
//   Others -> EXEC.
//  EXEC: 1 cycle, except MULT/DIV stay MULDIV_CYCLES cycles (down-counter).
//   Branch: pc_write=alu_zero, instr_done -> FETCH. LW/SW -> MEM. Else -> WB.
//  MEM: mem_req=1, mem_we=(SW). On mem_ready: SW -> instr_done, FETCH; LW -> WB.
//  WB: reg_write=1, instr_done=1 (JAL also pc_write=1) -> FETCH.
//  HALT: all strobes 0, mem_req 0, halted=1; exits only on rst.
//  Timeout: wait counter counts mem_req cycles without mem_ready in FETCH/MEM; clears on ready/state change.
//   Reaching MEM_TIMEOUT -> HALT with fault=1.
//  mem_ready while mem_req=0 is ignored. mem_ready on the first request cycle completes it (zero wait).
//  Nominal latency at zero-wait memory: R/I-ALU 4, LW 5, SW 4, BEQ/BNE/BLEZ/BGTZ 3, J/JR 2, JAL 3,
//   MULT/DIV 3+MULDIV_CYCLES cycles.
// STRUCTURE
//  Shared package mips_pkg:
//   - state_t enum: FETCH, DECODE, EXEC, MEM, WB, HALT.
//   - ctrl_bundle_t struct of select bits + alu_op.
//   - opcode/func and ALU-op constants, replacing the current macro files.
//  Sub-module mips_instr_decoder: combinational opcode/func -> ctrl_bundle_t + known/unknown flag.
//   Same decode table as the single-cycle CU.
//  Top holds FSM, DECODE register, mul/div and timeout counters.
// TESTING
//  1. rst high 2 cycles -> all strobes 0, sign_extend=1, halted=0. ADD with mem_ready tied 1 -> instr_done on cycle 4.
//   reg_write only in cycle 4; reg_dest=1, alu_op=ALU_ADD.
//  2. LW, mem_ready delayed 3 cycles in both FETCH and MEM -> mem_req held continuously.
//   instr_done at cycle 11; mem_to_reg=1 during WB.
//  3. SW -> mem_we=1 only in MEM; no reg_write pulse. BEQ with alu_zero=0 -> pc_write only in FETCH.
//   BEQ with alu_zero=1 -> pc_write in FETCH and EXEC.
//  4. MULT with MULDIV_CYCLES=8 -> EXEC lasts 8 cycles; reg_write at cycle 11; alu_op=ALU_MULT held throughout.
//  5. R-type func=6'b111111 -> halted=1 after DECODE, fault=0, no further mem_req.
//   MEM_TIMEOUT=4 with mem_ready=0 -> halted=fault=1 after 4 FETCH cycles.
//  6. rst asserted during MEM wait of SW -> next cycle FETCH, mem_we never seen with mem_ready, no instr_done.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, control
// bundle, opcode/func fields and ALU operation codes.
package mips_pkg;

  localparam int ALU_W = 5;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  typedef struct packed {
    logic [ALU_W-1:0] alu_op;
    logic             alu_src;
    logic             reg_dest;
    logic             mem_to_reg;
    logic             link;
    logic             sign_extend;
    logic             jump;
    logic             jump_reg;
    logic             branch;
    logic             mem_write;
    logic             muldiv;
  } ctrl_bundle_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_BLEZ  = 6'd6;
  localparam logic [5:0] OP_BGTZ  = 6'd7;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_SLTIU = 6'd11;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_SLL   = 6'd0;
  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_SRA   = 6'd3;
  localparam logic [5:0] FN_JR    = 6'd8;
  localparam logic [5:0] FN_MULT  = 6'd24;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIV   = 6'd26;
  localparam logic [5:0] FN_DIVU  = 6'd27;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_ADDU  = 6'd33;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_SUBU  = 6'd35;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_XOR   = 6'd38;
  localparam logic [5:0] FN_NOR   = 6'd39;
  localparam logic [5:0] FN_SLT   = 6'd42;
  localparam logic [5:0] FN_SLTU  = 6'd43;

  localparam logic [ALU_W-1:0] ALU_NOP   = 5'd0;
  localparam logic [ALU_W-1:0] ALU_ADD   = 5'd1;
  localparam logic [ALU_W-1:0] ALU_SUB   = 5'd2;
  localparam logic [ALU_W-1:0] ALU_AND   = 5'd3;
  localparam logic [ALU_W-1:0] ALU_OR    = 5'd4;
  localparam logic [ALU_W-1:0] ALU_XOR   = 5'd5;
  localparam logic [ALU_W-1:0] ALU_NOR   = 5'd6;
  localparam logic [ALU_W-1:0] ALU_SLT   = 5'd7;
  localparam logic [ALU_W-1:0] ALU_SLTU  = 5'd8;
  localparam logic [ALU_W-1:0] ALU_SLL   = 5'd9;
  localparam logic [ALU_W-1:0] ALU_SRL   = 5'd10;
  localparam logic [ALU_W-1:0] ALU_SRA   = 5'd11;
  localparam logic [ALU_W-1:0] ALU_LUI   = 5'd12;
  localparam logic [ALU_W-1:0] ALU_MULT  = 5'd13;
  localparam logic [ALU_W-1:0] ALU_MULTU = 5'd14;
  localparam logic [ALU_W-1:0] ALU_DIV   = 5'd15;
  localparam logic [ALU_W-1:0] ALU_DIVU  = 5'd16;
  localparam logic [ALU_W-1:0] ALU_BNE   = 5'd17;
  localparam logic [ALU_W-1:0] ALU_BLEZ  = 5'd18;
  localparam logic [ALU_W-1:0] ALU_BGTZ  = 5'd19;

  localparam ctrl_bundle_t CTRL_RESET = '{
    alu_op:      ALU_NOP,
    alu_src:     1'b0,
    reg_dest:    1'b0,
    mem_to_reg:  1'b0,
    link:        1'b0,
    sign_extend: 1'b1,
    jump:        1'b0,
    jump_reg:    1'b0,
    branch:      1'b0,
    mem_write:   1'b0,
    muldiv:      1'b0
  };

endpackage

// File: rtl/mips_instr_decoder.sv
// Combinational opcode/func decode into the control bundle, with flags
// for unknown opcodes (treated as NOP) and unknown R-type funcs (halt).
module mips_instr_decoder
  import mips_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   func,
  output ctrl_bundle_t ctrl,
  output logic         op_known,
  output logic         func_known
);

  always_comb begin
    ctrl       = CTRL_RESET;
    op_known   = 1'b1;
    func_known = 1'b1;
    unique case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dest = 1'b1;
        unique case (func)
          FN_ADD, FN_ADDU: ctrl.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: ctrl.alu_op = ALU_SUB;
          FN_AND:          ctrl.alu_op = ALU_AND;
          FN_OR:           ctrl.alu_op = ALU_OR;
          FN_XOR:          ctrl.alu_op = ALU_XOR;
          FN_NOR:          ctrl.alu_op = ALU_NOR;
          FN_SLT:          ctrl.alu_op = ALU_SLT;
          FN_SLTU:         ctrl.alu_op = ALU_SLTU;
          FN_SLL:          ctrl.alu_op = ALU_SLL;
          FN_SRL:          ctrl.alu_op = ALU_SRL;
          FN_SRA:          ctrl.alu_op = ALU_SRA;
          FN_MULT: begin
            ctrl.alu_op = ALU_MULT;
            ctrl.muldiv = 1'b1;
          end
          FN_MULTU: begin
            ctrl.alu_op = ALU_MULTU;
            ctrl.muldiv = 1'b1;
          end
          FN_DIV: begin
            ctrl.alu_op = ALU_DIV;
            ctrl.muldiv = 1'b1;
          end
          FN_DIVU: begin
            ctrl.alu_op = ALU_DIVU;
            ctrl.muldiv = 1'b1;
          end
          FN_JR: begin
            ctrl.reg_dest = 1'b0;
            ctrl.jump_reg = 1'b1;
          end
          default: func_known = 1'b0;
        endcase
      end
      OP_J: ctrl.jump = 1'b1;
      OP_JAL: begin
        ctrl.jump = 1'b1;
        ctrl.link = 1'b1;
      end
      OP_BEQ: begin
        ctrl.alu_op = ALU_SUB;
        ctrl.branch = 1'b1;
      end
      OP_BNE: begin
        ctrl.alu_op = ALU_BNE;
        ctrl.branch = 1'b1;
      end
      OP_BLEZ: begin
        ctrl.alu_op = ALU_BLEZ;
        ctrl.branch = 1'b1;
      end
      OP_BGTZ: begin
        ctrl.alu_op = ALU_BGTZ;
        ctrl.branch = 1'b1;
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl.alu_op  = ALU_ADD;
        ctrl.alu_src = 1'b1;
      end
      OP_SLTI: begin
        ctrl.alu_op  = ALU_SLT;
        ctrl.alu_src = 1'b1;
      end
      OP_SLTIU: begin
        ctrl.alu_op  = ALU_SLTU;
        ctrl.alu_src = 1'b1;
      end
      // logical immediates are zero-extended
      OP_ANDI: begin
        ctrl.alu_op      = ALU_AND;
        ctrl.alu_src     = 1'b1;
        ctrl.sign_extend = 1'b0;
      end
      OP_ORI: begin
        ctrl.alu_op      = ALU_OR;
        ctrl.alu_src     = 1'b1;
        ctrl.sign_extend = 1'b0;
      end
      OP_XORI: begin
        ctrl.alu_op      = ALU_XOR;
        ctrl.alu_src     = 1'b1;
        ctrl.sign_extend = 1'b0;
      end
      OP_LUI: begin
        ctrl.alu_op      = ALU_LUI;
        ctrl.alu_src     = 1'b1;
        ctrl.sign_extend = 1'b0;
      end
      OP_LW: begin
        ctrl.alu_op     = ALU_ADD;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_op    = ALU_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      default: op_known = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS controller: FETCH/DECODE/EXEC/MEM/WB sequencing with
// variable-latency memory handshake, iterative mul/div stall and timeout halt.
module multicycle_control_unit
  import mips_pkg::*;
#(
  parameter int ALUOP_W       = 5,
  parameter int MULDIV_CYCLES = 8,
  parameter int MEM_TIMEOUT   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               alu_zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               ir_write,
  output logic               pc_write,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_src,
  output logic               reg_dest,
  output logic               mem_to_reg,
  output logic               link,
  output logic               sign_extend,
  output logic               jump,
  output logic               jump_reg,
  output logic               branch,
  output logic               reg_write,
  output logic               instr_done,
  output logic               halted,
  output logic               fault
);

  localparam int CW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t       state;
  state_t       nxt;
  ctrl_bundle_t dec;
  ctrl_bundle_t bundle;
  ctrl_bundle_t sel;
  logic         op_known;
  logic         func_known;
  logic [CW-1:0] md_cnt;
  logic [TW-1:0] wait_cnt;
  logic         timeout_hit;
  logic         trip;
  logic         req_raw;
  logic         we_raw;
  logic         irw_raw;
  logic         pcw_raw;
  logic         rw_raw;
  logic         done_raw;

  mips_instr_decoder u_dec (
    .opcode     (opcode),
    .func       (func),
    .ctrl       (dec),
    .op_known   (op_known),
    .func_known (func_known)
  );

  // DECODE drives selects straight from the decoder so J/JR act that cycle
  assign sel = (state == DECODE) ? dec : bundle;

  assign timeout_hit = (MEM_TIMEOUT != 0) &&
                       (wait_cnt == TW'(MEM_TIMEOUT - 1));

  always_comb begin
    nxt      = state;
    req_raw  = 1'b0;
    we_raw   = 1'b0;
    irw_raw  = 1'b0;
    pcw_raw  = 1'b0;
    rw_raw   = 1'b0;
    done_raw = 1'b0;
    trip     = 1'b0;
    unique case (state)
      FETCH: begin
        req_raw = 1'b1;
        if (mem_ready) begin
          irw_raw = 1'b1;
          pcw_raw = 1'b1;
          nxt     = DECODE;
        end else if (timeout_hit) begin
          trip = 1'b1;
          nxt  = HALT;
        end
      end
      DECODE: begin
        if (!func_known) begin
          nxt = HALT;
        end else if (!op_known) begin
          done_raw = 1'b1;
          nxt      = FETCH;
        end else if (dec.jump && dec.link) begin
          nxt = WB;
        end else if (dec.jump || dec.jump_reg) begin
          pcw_raw  = 1'b1;
          done_raw = 1'b1;
          nxt      = FETCH;
        end else begin
          nxt = EXEC;
        end
      end
      EXEC: begin
        if (bundle.muldiv && md_cnt != '0) begin
          nxt = EXEC;
        end else if (bundle.branch) begin
          pcw_raw  = alu_zero;
          done_raw = 1'b1;
          nxt      = FETCH;
        end else if (bundle.mem_to_reg || bundle.mem_write) begin
          nxt = MEM;
        end else begin
          nxt = WB;
        end
      end
      MEM: begin
        req_raw = 1'b1;
        we_raw  = bundle.mem_write;
        if (mem_ready) begin
          if (bundle.mem_write) begin
            done_raw = 1'b1;
            nxt      = FETCH;
          end else begin
            nxt = WB;
          end
        end else if (timeout_hit) begin
          trip = 1'b1;
          nxt  = HALT;
        end
      end
      WB: begin
        rw_raw   = 1'b1;
        done_raw = 1'b1;
        pcw_raw  = bundle.link;
        nxt      = FETCH;
      end
      default: nxt = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      bundle   <= CTRL_RESET;
      md_cnt   <= '0;
      wait_cnt <= '0;
      fault    <= 1'b0;
    end else begin
      state <= nxt;
      if (state == DECODE) begin
        bundle <= dec;
        md_cnt <= CW'(MULDIV_CYCLES - 1);
      end else if (state == EXEC && md_cnt != '0) begin
        md_cnt <= md_cnt - 1'b1;
      end
      if (req_raw && !mem_ready && nxt == state)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
      if (trip)
        fault <= 1'b1;
    end
  end

  // reset abandons any in-flight request in the same cycle
  assign mem_req     = req_raw & ~rst;
  assign mem_we      = we_raw & ~rst;
  assign ir_write    = irw_raw & ~rst;
  assign pc_write    = pcw_raw & ~rst;
  assign reg_write   = rw_raw & ~rst;
  assign instr_done  = done_raw & ~rst;
  assign halted      = (state == HALT);

  assign alu_op      = ALUOP_W'(sel.alu_op);
  assign alu_src     = sel.alu_src;
  assign reg_dest    = sel.reg_dest;
  assign mem_to_reg  = sel.mem_to_reg;
  assign link        = sel.link;
  assign sign_extend = sel.sign_extend;
  assign jump        = sel.jump;
  assign jump_reg    = sel.jump_reg;
  assign branch      = sel.branch;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-instruction cycle schedules are
// derived from the latency rules and compared cycle by cycle.
module tb_multicycle_control_unit;
  import mips_pkg::*;

  localparam int MDC = 8;
  localparam int TMO = 4;

  localparam int K_ALU = 0;
  localparam int K_MD  = 1;
  localparam int K_LW  = 2;
  localparam int K_SW  = 3;
  localparam int K_BR  = 4;
  localparam int K_J   = 5;
  localparam int K_JAL = 6;
  localparam int K_JR  = 7;
  localparam int K_NOP = 8;
  localparam int K_BAD = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] func = '0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, ir_write, pc_write;
  logic [4:0] alu_op;
  logic       alu_src, reg_dest, mem_to_reg, link, sign_extend;
  logic       jump, jump_reg, branch;
  logic       reg_write, instr_done, halted, fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rdy;
    logic       zero;
    logic [5:0] stb;
    logic       chk_sel;
  } step_t;

  step_t sq[$];

  multicycle_control_unit #(
    .ALUOP_W(5), .MULDIV_CYCLES(MDC), .MEM_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
    .pc_write(pc_write), .alu_op(alu_op), .alu_src(alu_src),
    .reg_dest(reg_dest), .mem_to_reg(mem_to_reg), .link(link),
    .sign_extend(sign_extend), .jump(jump), .jump_reg(jump_reg),
    .branch(branch), .reg_write(reg_write), .instr_done(instr_done),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] strobes();
    return {mem_req, mem_we, ir_write, pc_write, reg_write, instr_done};
  endfunction

  function automatic logic [12:0] selects();
    return {alu_op, alu_src, reg_dest, mem_to_reg, link,
            sign_extend, jump, jump_reg, branch};
  endfunction

  function automatic logic [12:0] mk(
    input logic [4:0] a, input logic s, input logic rd,
    input logic m2r, input logic lk, input logic sx,
    input logic j, input logic jr, input logic br);
    return {a, s, rd, m2r, lk, sx, j, jr, br};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic classify(input logic [5:0] op, input logic [5:0] fn,
                          output int kind, output logic [12:0] sel);
    kind = K_NOP;
    sel  = mk(ALU_NOP, 0, 0, 0, 0, 1, 0, 0, 0);
    case (op)
      6'd0: begin
        kind = K_ALU;
        case (fn)
          6'd32, 6'd33: sel = mk(ALU_ADD, 0, 1, 0, 0, 1, 0, 0, 0);
          6'd34, 6'd35: sel = mk(ALU_SUB, 0, 1, 0, 0, 1, 0, 0, 0);
          6'd36: sel = mk(ALU_AND, 0, 1, 0, 0, 1, 0, 0, 0);
          6'd37: sel = mk(ALU_OR, 0, 1, 0, 0, 1, 0, 0, 0);
          6'd38: sel = mk(ALU_XOR, 0, 1, 0, 0, 1, 0, 0, 0);
          6'd39: sel = mk(ALU_NOR, 0, 1, 0, 0, 1, 0, 0, 0);
          6'd42: sel = mk(ALU_SLT, 0, 1, 0, 0, 1, 0, 0, 0);
          6'd43: sel = mk(ALU_SLTU, 0, 1, 0, 0, 1, 0, 0, 0);
          6'd0:  sel = mk(ALU_SLL, 0, 1, 0, 0, 1, 0, 0, 0);
          6'd2:  sel = mk(ALU_SRL, 0, 1, 0, 0, 1, 0, 0, 0);
          6'd3:  sel = mk(ALU_SRA, 0, 1, 0, 0, 1, 0, 0, 0);
          6'd24: begin kind = K_MD; sel = mk(ALU_MULT, 0, 1, 0, 0, 1, 0, 0, 0); end
          6'd25: begin kind = K_MD; sel = mk(ALU_MULTU, 0, 1, 0, 0, 1, 0, 0, 0); end
          6'd26: begin kind = K_MD; sel = mk(ALU_DIV, 0, 1, 0, 0, 1, 0, 0, 0); end
          6'd27: begin kind = K_MD; sel = mk(ALU_DIVU, 0, 1, 0, 0, 1, 0, 0, 0); end
          6'd8:  begin kind = K_JR; sel = mk(ALU_NOP, 0, 0, 0, 0, 1, 0, 1, 0); end
          default: kind = K_BAD;
        endcase
      end
      6'd2:  begin kind = K_J;   sel = mk(ALU_NOP, 0, 0, 0, 0, 1, 1, 0, 0); end
      6'd3:  begin kind = K_JAL; sel = mk(ALU_NOP, 0, 0, 0, 1, 1, 1, 0, 0); end
      6'd4:  begin kind = K_BR;  sel = mk(ALU_SUB, 0, 0, 0, 0, 1, 0, 0, 1); end
      6'd5:  begin kind = K_BR;  sel = mk(ALU_BNE, 0, 0, 0, 0, 1, 0, 0, 1); end
      6'd6:  begin kind = K_BR;  sel = mk(ALU_BLEZ, 0, 0, 0, 0, 1, 0, 0, 1); end
      6'd7:  begin kind = K_BR;  sel = mk(ALU_BGTZ, 0, 0, 0, 0, 1, 0, 0, 1); end
      6'd8, 6'd9: begin kind = K_ALU; sel = mk(ALU_ADD, 1, 0, 0, 0, 1, 0, 0, 0); end
      6'd10: begin kind = K_ALU; sel = mk(ALU_SLT, 1, 0, 0, 0, 1, 0, 0, 0); end
      6'd11: begin kind = K_ALU; sel = mk(ALU_SLTU, 1, 0, 0, 0, 1, 0, 0, 0); end
      6'd12: begin kind = K_ALU; sel = mk(ALU_AND, 1, 0, 0, 0, 0, 0, 0, 0); end
      6'd13: begin kind = K_ALU; sel = mk(ALU_OR, 1, 0, 0, 0, 0, 0, 0, 0); end
      6'd14: begin kind = K_ALU; sel = mk(ALU_XOR, 1, 0, 0, 0, 0, 0, 0, 0); end
      6'd15: begin kind = K_ALU; sel = mk(ALU_LUI, 1, 0, 0, 0, 0, 0, 0, 0); end
      6'd35: begin kind = K_LW;  sel = mk(ALU_ADD, 1, 0, 1, 0, 1, 0, 0, 0); end
      6'd43: begin kind = K_SW;  sel = mk(ALU_ADD, 1, 0, 0, 0, 1, 0, 0, 0); end
      default: kind = K_NOP;
    endcase
  endtask

  task automatic push(input logic r, input logic z, input logic [5:0] s,
                      input logic c);
    step_t st;
    st.rdy = r; st.zero = z; st.stb = s; st.chk_sel = c;
    sq.push_back(st);
  endtask

  function automatic logic noise();
    return 1'($urandom_range(1, 0));
  endfunction

  // strobe vector order: mem_req, mem_we, ir_write, pc_write, reg_write, instr_done
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int df, input int dm);
    int kind;
    logic [12:0] esel;
    int n;
    classify(op, fn, kind, esel);
    sq.delete();
    for (int i = 0; i <= df; i++)
      push(i == df, noise(), {1'b1, 1'b0, i == df, i == df, 2'b00}, 1'b0);
    case (kind)
      K_NOP:      push(noise(), noise(), 6'b000001, 1'b1);
      K_J, K_JR:  push(noise(), noise(), 6'b000101, 1'b1);
      K_BAD:      push(noise(), noise(), 6'b000000, 1'b0);
      default:    push(noise(), noise(), 6'b000000, 1'b1);
    endcase
    if (kind == K_JAL)
      push(noise(), noise(), 6'b000111, 1'b1);
    if (kind inside {K_ALU, K_MD, K_LW, K_SW, K_BR}) begin
      n = (kind == K_MD) ? MDC : 1;
      for (int i = 0; i < n; i++) begin
        if (kind == K_BR)
          push(noise(), z, {3'b000, z, 2'b01}, 1'b1);
        else
          push(noise(), noise(), 6'b000000, 1'b1);
      end
    end
    if (kind == K_LW || kind == K_SW)
      for (int i = 0; i <= dm; i++)
        push(i == dm, noise(),
             {1'b1, kind == K_SW, 3'b000, kind == K_SW && i == dm}, 1'b1);
    if (kind inside {K_ALU, K_MD, K_LW})
      push(noise(), noise(), 6'b000011, 1'b1);
    for (int i = 0; i < sq.size(); i++) begin
      @(negedge clk);
      opcode = op; func = fn;
      mem_ready = sq[i].rdy; alu_zero = sq[i].zero;
      #1;
      check($sformatf("strobes op%0d fn%0d cyc%0d", op, fn, i + 1),
            32'(strobes()), 32'(sq[i].stb));
      if (sq[i].chk_sel)
        check($sformatf("selects op%0d fn%0d cyc%0d", op, fn, i + 1),
              32'(selects()), 32'(esel));
    end
    if (kind == K_BAD) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        mem_ready = noise();
        #1;
        check("bad_func halted", 32'(halted), 32'd1);
        check("bad_func fault", 32'(fault), 32'd0);
        check("bad_func quiet", 32'(strobes()), 32'd0);
      end
    end else begin
      check("not halted", 32'(halted), 32'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; mem_ready = noise();
    #1;
    check("reset strobes a", 32'(strobes()), 32'd0);
    @(negedge clk);
    mem_ready = noise();
    #1;
    check("reset strobes b", 32'(strobes()), 32'd0);
    check("reset selects", 32'(selects()),
          32'(mk(ALU_NOP, 0, 0, 0, 0, 1, 0, 0, 0)));
    check("reset halted", 32'({halted, fault}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; mem_ready = 1'b0;
  endtask

  logic [5:0] rops[16] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd2, 6'd3, 6'd4,
                           6'd5, 6'd7, 6'd8, 6'd13, 6'd15, 6'd35,
                           6'd43, 6'd0, 6'd50};
  logic [5:0] rfns[16] = '{6'd32, 6'd39, 6'd3, 6'd25, 6'd0, 6'd0, 6'd0,
                           6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0,
                           6'd0, 6'd8, 6'd0};

  initial begin
    int idx;
    do_reset();
    run_instr(OP_RTYPE, FN_ADD, 1'b0, 0, 0);
    run_instr(OP_LW, 6'd0, 1'b0, 3, 3);
    run_instr(OP_SW, 6'd0, 1'b0, 0, 0);
    run_instr(OP_BEQ, 6'd0, 1'b0, 0, 0);
    run_instr(OP_BEQ, 6'd0, 1'b1, 0, 0);
    run_instr(OP_RTYPE, FN_MULT, 1'b0, 0, 0);
    run_instr(OP_J, 6'd0, 1'b0, 0, 0);
    run_instr(OP_JAL, 6'd0, 1'b0, 1, 0);
    run_instr(OP_RTYPE, FN_JR, 1'b0, 0, 0);
    run_instr(6'd63, 6'd0, 1'b0, 0, 0);
    run_instr(OP_RTYPE, 6'b111111, 1'b0, 0, 0);

    do_reset();
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      check("timeout waiting req", 32'({mem_req, halted}), 32'b10);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check("timeout halt", 32'({halted, fault, mem_req}), 32'b110);

    do_reset();
    @(negedge clk);
    opcode = OP_SW; mem_ready = 1'b1;
    #1;
    check("sw fetch", 32'(strobes()), 32'b101100);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("sw decode", 32'(strobes()), 32'd0);
    @(negedge clk);
    #1;
    check("sw exec", 32'(strobes()), 32'd0);
    @(negedge clk);
    #1;
    check("sw mem wait", 32'(strobes()), 32'b110000);
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b1;
    #1;
    check("sw reset cycle", 32'(strobes()), 32'd0);
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    check("after reset fetch", 32'({strobes(), halted}), 32'b1000000);
    run_instr(OP_RTYPE, FN_SUB, 1'b0, 0, 0);

    for (int k = 0; k < 60; k++) begin
      idx = $urandom_range(15, 0);
      run_instr(rops[idx], rfns[idx], noise(),
                $urandom_range(2, 0), $urandom_range(2, 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
